// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - CP0 register numbers, decode codes and field positions
package cp0_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] RS_MFC0   = 5'b00000;
  localparam logic [4:0] RS_MTC0   = 5'b00100;
  localparam logic [4:0] RS_CO     = 5'b10000;
  localparam logic [5:0] FUNC_ERET = 6'b011000;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LO   = 8;
  localparam int ST_IM_HI   = 15;
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;
  localparam int IP_TIMER   = 7;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_INT,
    ACT_SYS,
    ACT_ERET
  } cp0_action_e;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and the sticky timer interrupt bit
module cp0_timer
  import cp0_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_ip
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_ip_q, timer_ip_d;

  always_comb begin
    count_d    = count_we ? wdata : count_q + 32'd1;
    compare_d  = compare_we ? wdata : compare_q;
    // A Compare write acknowledges the timer interrupt; Compare==0 disables the match.
    timer_ip_d = compare_we ? 1'b0
               : (timer_ip_q | ((count_q == compare_q) && (compare_q != 32'd0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      timer_ip_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      timer_ip_q <= timer_ip_d;
    end
  end

  assign count    = count_q;
  assign compare  = compare_q;
  assign timer_ip = timer_ip_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 responder: MFC0/MTC0/ERET, syscall and interrupt redirect
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          NIRQ         = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iscop0,
  input  logic [4:0]      cop0_rs,
  input  logic [5:0]      func,
  input  logic [4:0]      cop0_rd,
  input  logic [31:0]     wdata,
  input  logic            issyscall,
  input  logic [31:0]     pc,
  input  logic [NIRQ-1:0] irq,
  output logic [31:0]     rdata,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            suppress,
  output logic            exc_active
);

  logic            ie_q, ie_d;
  logic            exl_q, exl_d;
  logic [7:0]      im_q, im_d;
  logic [4:0]      exc_q, exc_d;
  logic [31:0]     epc_q, epc_d;
  logic [NIRQ-1:0] irq_q, irq_d;

  logic [31:0] count, compare;
  logic        timer_ip;
  logic [7:0]  ip;
  logic        is_mfc0, is_mtc0, is_eret, int_req, mtc0_en;
  logic [31:0] status_val, cause_val, rd_mux;
  cp0_action_e action;

  always_comb begin
    ip               = 8'd0;
    ip[NIRQ-1:0]     = irq_q;
    ip[IP_TIMER]     = timer_ip;
    status_val       = 32'd0;
    status_val[ST_IE]               = ie_q;
    status_val[ST_EXL]              = exl_q;
    status_val[ST_IM_HI:ST_IM_LO]   = im_q;
    cause_val        = 32'd0;
    cause_val[CA_EXC_HI:CA_EXC_LO]  = exc_q;
    cause_val[15:8]                 = ip;
  end

  assign is_mfc0 = iscop0 && (cop0_rs == RS_MFC0);
  assign is_mtc0 = iscop0 && (cop0_rs == RS_MTC0);
  assign is_eret = iscop0 && (cop0_rs == RS_CO) && (func == FUNC_ERET);
  assign int_req = ie_q & ~exl_q & (|(ip & im_q));
  // A taken interrupt or syscall owns this cycle, so an MTC0 alongside is dropped.
  assign mtc0_en = is_mtc0 & ~int_req & ~issyscall;

  always_comb begin
    if (int_req)        action = ACT_INT;
    else if (issyscall) action = ACT_SYS;
    else if (is_eret)   action = ACT_ERET;
    else                action = ACT_NONE;
  end

  always_comb begin
    case (cop0_rd)
      CP0_COUNT:   rd_mux = count;
      CP0_COMPARE: rd_mux = compare;
      CP0_STATUS:  rd_mux = status_val;
      CP0_CAUSE:   rd_mux = cause_val;
      CP0_EPC:     rd_mux = epc_q;
      default:     rd_mux = 32'd0;
    endcase
  end

  assign rdata       = (!rst && is_mfc0) ? rd_mux : 32'd0;
  assign redirect    = !rst && (action != ACT_NONE);
  assign redirect_pc = (action == ACT_ERET) ? epc_q : HANDLER_ADDR;
  assign suppress    = !rst && (action == ACT_INT);
  assign exc_active  = exl_q;

  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im_d  = im_q;
    exc_d = exc_q;
    epc_d = epc_q;
    irq_d = irq;
    if (mtc0_en) begin
      case (cop0_rd)
        CP0_STATUS: begin
          ie_d  = wdata[ST_IE];
          exl_d = wdata[ST_EXL];
          im_d  = wdata[ST_IM_HI:ST_IM_LO];
        end
        CP0_CAUSE: exc_d = wdata[CA_EXC_HI:CA_EXC_LO];
        CP0_EPC:   epc_d = wdata;
        default: ;
      endcase
    end
    case (action)
      ACT_INT: begin
        epc_d = pc;
        exl_d = 1'b1;
        exc_d = EXC_INT;
      end
      ACT_SYS: begin
        epc_d = pc;
        exl_d = 1'b1;
        exc_d = EXC_SYS;
      end
      ACT_ERET: exl_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= 8'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
      irq_q <= '0;
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im_q  <= im_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
      irq_q <= irq_d;
    end
  end

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_en && (cop0_rd == CP0_COUNT)),
    .compare_we (mtc0_en && (cop0_rd == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .timer_ip   (timer_ip)
  );

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed scoreboard bench for cp0_unit
module tb_cp0_unit;

  localparam logic [31:0] H = 32'h0000_4180;
  localparam int K_NOP = 0, K_MFC0 = 1, K_MTC0 = 2, K_ERET = 3, K_SYS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iscop0 = 1'b0;
  logic [4:0]  cop0_rs = 5'd0;
  logic [5:0]  func = 6'd0;
  logic [4:0]  cop0_rd = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic        issyscall = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [2:0]  irq = 3'd0;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        suppress;
  logic        exc_active;

  typedef struct {
    logic        red;
    logic [31:0] rpc;
    logic        sup;
    logic [31:0] rd;
    logic        exl;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  logic in_valid = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cp0_unit #(.HANDLER_ADDR(32'h0000_4180), .NIRQ(3)) dut (
    .clk(clk), .rst(rst), .iscop0(iscop0), .cop0_rs(cop0_rs), .func(func),
    .cop0_rd(cop0_rd), .wdata(wdata), .issyscall(issyscall), .pc(pc), .irq(irq),
    .rdata(rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .suppress(suppress), .exc_active(exc_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, id, got, want);
    end
  endtask

  // Monitor: every presented instruction cycle pops one expectation.
  always @(negedge clk) begin
    if (in_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty vec=? got=0 expected=1");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("redirect", e.id, {31'd0, redirect}, {31'd0, e.red});
        if (e.red) chk("redirect_pc", e.id, redirect_pc, e.rpc);
        chk("suppress", e.id, {31'd0, suppress}, {31'd0, e.sup});
        chk("rdata", e.id, rdata, e.rd);
        chk("exc_active", e.id, {31'd0, exc_active}, {31'd0, e.exl});
      end
    end
  end

  task automatic ins(input logic r, input int k, input logic [4:0] rd, input logic [31:0] wd,
                     input logic [31:0] p, input logic [2:0] iq,
                     input logic e_red, input logic [31:0] e_pc, input logic e_sup,
                     input logic [31:0] e_rd, input logic e_exl);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    iscop0    = (k == K_MFC0) || (k == K_MTC0) || (k == K_ERET);
    cop0_rs   = (k == K_MTC0) ? 5'b00100 : (k == K_ERET) ? 5'b10000 : 5'b00000;
    func      = (k == K_ERET) ? 6'b011000 : 6'd0;
    cop0_rd   = rd;
    wdata     = wd;
    issyscall = (k == K_SYS);
    pc        = p;
    irq       = iq;
    e.red = e_red; e.rpc = e_pc; e.sup = e_sup; e.rd = e_rd; e.exl = e_exl; e.id = cyc;
    exp_q.push_back(e);
    in_valid = 1'b1;
    cyc++;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    // r  kind    rd  wdata          pc            irq   red rpc           sup rdata          exl
    ins(1, K_SYS,  0, 32'h0,         32'h3000, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 12, 32'h0,        32'h3000, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MTC0, 12, 32'h101,      32'h3004, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 12, 32'h0,        32'h3008, 3'b1, 0, 32'h0,     0, 32'h101,      0);
    ins(0, K_NOP,  0, 32'h0,         32'h3010, 3'b1, 1, H,         1, 32'h0,        0);
    ins(0, K_MFC0, 14, 32'h0,        32'h4180, 3'b1, 0, 32'h0,     0, 32'h3010,     1);
    ins(0, K_MFC0, 13, 32'h0,        32'h4184, 3'b0, 0, 32'h0,     0, 32'h100,      1);
    ins(0, K_MFC0, 12, 32'h0,        32'h4188, 3'b0, 0, 32'h0,     0, 32'h103,      1);
    ins(0, K_MTC0, 12, 32'h100,      32'h418c, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_SYS,  0, 32'h0,         32'h3020, 3'b0, 1, H,         0, 32'h0,        0);
    ins(0, K_MFC0, 13, 32'h0,        32'h4180, 3'b0, 0, 32'h0,     0, 32'h20,       1);
    ins(0, K_MFC0, 14, 32'h0,        32'h4184, 3'b0, 0, 32'h0,     0, 32'h3020,     1);
    ins(0, K_MTC0, 14, 32'h3024,     32'h4188, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 12, 32'h103,      32'h418c, 3'b1, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_ERET, 0, 32'h0,         32'h4190, 3'b1, 1, 32'h3024,  0, 32'h0,        1);
    ins(0, K_NOP,  0, 32'h0,         32'h3030, 3'b1, 1, H,         1, 32'h0,        0);
    ins(0, K_MTC0, 12, 32'h8001,     32'h4180, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 11, 32'h5,        32'h3030, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MTC0, 9, 32'h0,         32'h3034, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 9, 32'h0,         32'h3038, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_NOP,  0, 32'h0,         32'h303c, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_NOP,  0, 32'h0,         32'h3040, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 9, 32'h0,         32'h3044, 3'b0, 0, 32'h0,     0, 32'h3,        0);
    ins(0, K_NOP,  0, 32'h0,         32'h3048, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 13, 32'h0,        32'h304c, 3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_NOP,  0, 32'h0,         32'h3050, 3'b0, 1, H,         1, 32'h0,        0);
    ins(0, K_MFC0, 13, 32'h0,        32'h4180, 3'b0, 0, 32'h0,     0, 32'h8000,     1);
    ins(0, K_MTC0, 11, 32'd20,       32'h4184, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MFC0, 13, 32'h0,        32'h4188, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 11, 32'h0,        32'h418c, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 12, 32'h101,      32'h4190, 3'b1, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_SYS,  0, 32'h0,         32'h3040, 3'b1, 1, H,         1, 32'h0,        0);
    ins(0, K_MFC0, 14, 32'h0,        32'h4180, 3'b0, 0, 32'h0,     0, 32'h3040,     1);
    ins(0, K_MFC0, 13, 32'h0,        32'h4184, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MFC0, 7, 32'h0,         32'h4188, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 7, 32'hffff_ffff, 32'h418c, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MFC0, 7, 32'h0,         32'h4190, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 12, 32'h101,      32'h4194, 3'b1, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MTC0, 14, 32'hdead,     32'h3060, 3'b1, 1, H,         1, 32'h0,        0);
    ins(0, K_MFC0, 14, 32'h0,        32'h4180, 3'b0, 0, 32'h0,     0, 32'h3060,     1);
    ins(1, K_MFC0, 14, 32'h0,        32'h4184, 3'b0, 0, 32'h0,     0, 32'h0,        1);
    ins(0, K_MFC0, 14, 32'h0,        32'h0,    3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 12, 32'h0,        32'h4,    3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 13, 32'h0,        32'h8,    3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 11, 32'h0,        32'hc,    3'b0, 0, 32'h0,     0, 32'h0,        0);
    ins(0, K_MFC0, 9, 32'h0,         32'h10,   3'b0, 0, 32'h0,     0, 32'h4,        0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    iscop0 = 1'b0;
    issyscall = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 responder for the single-cycle MIPS core. Sits on the other end of the control unit's `iscop0`/`issyscall` decode outputs.
- Executes MFC0/MTC0/ERET and owns Status, Cause, EPC, Count and Compare.
- Arbitrates syscall and external/timer interrupts. Returns a same-cycle PC redirect to the fetch mux.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt vector driven on `redirect_pc`.
- NIRQ, 3, number of external interrupt lines (max 5), mapped to Cause.IP[10:8].

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- iscop0  in  1  current instruction is opcode 010000.
- cop0_rs  in  5  instr[25:21]: 00000=MFC0, 00100=MTC0, 10000=CO (ERET when funct=011000).
- func  in  6  instr[5:0].
- cop0_rd  in  5  CP0 register number, instr[15:11].
- wdata  in  32  GPR[rt] for MTC0.
- issyscall  in  1  current instruction is SYSCALL.
- pc  in  32  PC of the current instruction.
- irq  in  NIRQ  level-sensitive external interrupt requests.
- rdata  out  32  MFC0 result, combinational.
- redirect  out  1  fetch must load `redirect_pc` instead of the sequential/branch PC.
- redirect_pc  out  32  HANDLER_ADDR on an exception; EPC on ERET.
- suppress  out  1  current instruction must not commit (GPR/memory write enables gated).
- exc_active  out  1  Status.EXL.

Behaviour:
- Registers and reset values (all 0 on `rst`):
  - Count (9): +1 every cycle, wraps 2^32-1 -> 0.
  - Compare (11).
  - Status (12): bit0 IE, bit1 EXL, bits[15:8] IM; other bits read 0.
  - Cause (13): bits[6:2] ExcCode, bits[15:8] IP; other bits read 0.
  - EPC (14).
  - Unimplemented register numbers read 0; writes to them are ignored.
- Interrupt pending:
  - IP[8+i] = irq[i], sampled each clock.
  - IP[15] is set when Count==Compare and Compare!=0. It stays set until an MTC0 to Compare clears it.
- int_req = IE & ~EXL & |(IP & IM), using registered IP.
- Priority, evaluated combinationally each cycle:
  - 1. int_req: redirect=1, redirect_pc=HANDLER_ADDR, suppress=1. At the edge: EPC<=pc, EXL<=1, ExcCode<=0.
  - 2. issyscall (unmaskable, taken even when EXL=1): redirect=1, redirect_pc=HANDLER_ADDR, suppress=0. At the edge: EPC<=pc, EXL<=1, ExcCode<=8. Software advances EPC by 4.
  - 3. ERET (iscop0, rs=10000, func=011000): redirect=1, redirect_pc=EPC. At the edge: EXL<=0.
  - 4. MTC0: register write at the edge.
  - 5. MFC0: rdata=register value (pre-edge value).
- When an interrupt is taken, any MTC0/ERET in the same cycle is discarded.
- While rst=1: redirect=0, suppress=0, rdata=0.
- MTC0 to Count in the same cycle as the increment: the written value wins, with no +1 that cycle.
- MTC0 to Cause writes only IP[9:8]-style software bits? No: Cause is read-only except ExcCode clear. MTC0 to Cause writes only bits[6:2].
- MTC0 to Status then interrupt: the new IE/IM take effect from the next cycle.
- Reset mid-handler clears EXL and EPC; no redirect is issued.
- Latency:
  - Redirect and suppress: 0 cycles, combinational.
  - Register updates: visible on the next cycle.
  - irq to IP: 1 cycle.
  - IP to redirect: combinational on the instruction of that cycle.

Decomposition:
- Shared package holds:
  - CP0 register numbers: CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - rs codes: RS_MFC0, RS_MTC0, RS_CO; FUNC_ERET=011000.
  - ExcCodes: EXC_INT=0, EXC_SYS=8.
  - Status/Cause bit-index constants.
- One natural sub-module, cp0_timer: Count/Compare/IP[15] logic with write ports.

Test Plan:
- Reset, then MTC0 Status=32'h0000_0101, hold irq[0]=1 with pc=32'h0000_3010 -> IP[8] set after 1 cycle. Next instruction: redirect=1, redirect_pc=32'h0000_4180, suppress=1. Then EPC=32'h0000_3010, EXL=1, ExcCode=0.
- SYSCALL at pc=32'h0000_3020 with IE=0 -> redirect to 32'h0000_4180, suppress=0. Then EPC=32'h0000_3020, Cause[6:2]=8.
- In the handler, MTC0 EPC=32'h0000_3024, then ERET -> redirect_pc=32'h0000_3024, EXL=0 next cycle. An irq held during EXL=1 must not redirect until after ERET.
- MTC0 Compare=5, Count=0, IM[15]=1, IE=1 -> IP[15] sets when Count reaches 5, interrupt is taken. MTC0 Compare=20 clears IP[15].
- Same-cycle irq-ready and SYSCALL at pc=32'h0000_3040 -> interrupt wins: ExcCode=0, suppress=1, EPC=32'h0000_3040.
- MFC0 to rd=7 returns 0. MTC0 rd=7 has no effect. Assert rst while EXL=1 -> all registers 0, redirect=0.
